// File: rtl/kcpsm3_int_ctrl_pkg.sv
// Shared types and default port addresses for the KCPSM3 interrupt controller.
package kcpsm3_int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_ACKED = 2'b10
  } irq_state_e;

  localparam logic [7:0] DEF_STATUS_PORT = 8'h10;
  localparam logic [7:0] DEF_MASK_PORT   = 8'h11;

endpackage

// File: rtl/kcpsm3_int_ctrl_if.sv
// KCPSM3 port bus plus interrupt handshake, seen from processor (master) and peripheral (slave).
interface kcpsm3_int_ctrl_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       write_strobe;
  logic       read_strobe;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/kcpsm3_int_ctrl_int_edge_latch.sv
// Rising-edge detector feeding a pending register; a same-cycle set beats a clear.
module int_edge_latch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] src_i,
  input  logic [W-1:0] clr_i,
  output logic [W-1:0] pending_o
);

  logic [W-1:0] src_q;
  logic [W-1:0] pending_q;
  logic [W-1:0] pending_d;

  assign pending_d = (pending_q & ~clr_i) | (src_i & ~src_q);
  assign pending_o = pending_q;

  // src_q resets high so lines already asserted at reset release are not events
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src_q     <= '1;
      pending_q <= '0;
    end else begin
      src_q     <= src_i;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/kcpsm3_int_ctrl.sv
// KCPSM3 interrupt controller: mask register, request/ack FSM and registered read mux.
module kcpsm3_int_ctrl
  import kcpsm3_int_pkg::*;
#(
  parameter int         N_SRC       = 8,
  parameter logic [7:0] STATUS_PORT = DEF_STATUS_PORT,
  parameter logic [7:0] MASK_PORT   = DEF_MASK_PORT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] src,
  kcpsm3_int_ctrl_if.slave bus
);

  logic             status_wr;
  logic             mask_wr;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] mask_d;
  logic             active;
  logic [7:0]       in_port_d;
  logic [7:0]       in_port_q;
  irq_state_e       state_q;
  logic             irq_q;

  assign status_wr = bus.write_strobe && (bus.port_id == STATUS_PORT);
  assign mask_wr   = bus.write_strobe && (bus.port_id == MASK_PORT);
  assign clr       = status_wr ? bus.out_port[N_SRC-1:0] : '0;
  assign mask_d    = mask_wr ? bus.out_port[N_SRC-1:0] : mask_q;
  assign active    = |(pending & mask_q);

  int_edge_latch #(.W(N_SRC)) u_edge_latch (
    .clk       (clk),
    .reset_n   (reset_n),
    .src_i     (src),
    .clr_i     (clr),
    .pending_o (pending)
  );

  always_comb begin
    in_port_d = '0;
    if (bus.port_id == STATUS_PORT) begin
      in_port_d[N_SRC-1:0] = pending;
    end else if (bus.port_id == MASK_PORT) begin
      in_port_d[N_SRC-1:0] = mask_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q    <= '0;
      in_port_q <= '0;
    end else begin
      mask_q    <= mask_d;
      in_port_q <= in_port_d;
    end
  end

  // Once raised, the request is held until acknowledged even if active drops;
  // a status write after the ack re-arms the controller.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (active) begin
            state_q <= ST_REQ;
            irq_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.interrupt_ack) begin
            state_q <= ST_ACKED;
            irq_q   <= 1'b0;
          end
        end
        ST_ACKED: begin
          if (status_wr) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_port   = in_port_q;
  assign bus.interrupt = irq_q;

endmodule
